// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   modport master (output start, a, b, bin, input busy, done, diff, bout);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor step per clock
module serial_subtractor #(parameter int WIDTH = 8) (
   input logic               clk,
   input logic               rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] op_a, op_b, res, res_nx, diff;
   logic [CW-1:0]    cnt;
   logic             brw, brw_nx, d, bout, last;
   // state register; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // full-subtractor cell on the current LSBs, result shift-in at the MSB, next-state decode
   always_comb begin
      d        = op_a[0] ^ op_b[0] ^ brw;
      brw_nx   = (~op_a[0] & op_b[0]) | (~(op_a[0] ^ op_b[0]) & brw);
      res_nx   = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
      last     = cnt == CW'(WIDTH - 1);
      state_nx = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
   end
   // operand load on accept, serial shifting during RUN, result published only on the last bit
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         op_a <= '0;
         op_b <= '0;
         res  <= '0;
         brw  <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         op_a <= bus.a;
         op_b <= bus.b;
         brw  <= bus.bin;
         cnt  <= '0;
      end else if (state == RUN) begin
         op_a <= op_a >> 1;
         op_b <= op_b >> 1;
         res  <= res_nx;
         brw  <= brw_nx;
         cnt  <= cnt + 1'b1;
         if (last) begin
            diff <= res_nx;
            bout <= brw_nx;
         end
      end
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.diff = diff;
   assign bus.bout = bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of the serial subtractor against arithmetic a - b - bin
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] last_d = '0;
   logic       last_b = 1'b0;
   serial_subtractor_if #(.WIDTH(8)) m ();
   serial_subtractor_if #(.WIDTH(1)) s ();
   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(m));
   serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(s));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one 8-bit operation; poke re-asserts start with other operands mid-RUN
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi, input bit poke);
      int   nb = 0;
      logic held = 1'b1;
      int   ed;
      logic eb;
      @(negedge clk);
      m.start = 1'b1; m.a = av; m.b = bv; m.bin = bi;
      @(negedge clk);
      m.start = 1'b0; m.a = 8'($urandom); m.b = 8'($urandom); m.bin = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         nb += int'(m.busy);
         held &= (m.diff === last_d) && (m.bout === last_b) && (m.done === 1'b0);
         if (poke) begin
            m.start = (i == 2);
            if (i == 2) begin m.a = ~av; m.b = av; end
         end
      end
      check("busy_cycles", nb, 8);
      check("hold_during_run", 32'(held), 1);
      @(negedge clk);
      ed = (int'(av) - int'(bv) - int'(bi)) & 8'hFF;
      eb = int'(av) < int'(bv) + int'(bi);
      check("done", 32'(m.done), 1);
      check("busy_in_done", 32'(m.busy), 0);
      check($sformatf("diff %02h-%02h-%0d", av, bv, bi), 32'(m.diff), 32'(ed));
      check($sformatf("bout %02h-%02h-%0d", av, bv, bi), 32'(m.bout), 32'(eb));
      last_d = 8'(ed);
      last_b = eb;
   endtask

   initial begin
      logic [2:0] combos [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
      int n;
      m.start = 1'b0; m.a = '0; m.b = '0; m.bin = 1'b0;
      s.start = 1'b0; s.a = '0; s.b = '0; s.bin = 1'b0;
      #12;
      check("reset_busy", 32'(m.busy), 0);
      check("reset_done", 32'(m.done), 0);
      check("reset_diff", 32'(m.diff), 0);
      check("reset_bout", 32'(m.bout), 0);
      @(negedge clk); rst = 1'b0;
      op8(8'h5A, 8'h3C, 1'b0, 1'b0);
      op8(8'h00, 8'h01, 1'b0, 1'b0);
      op8(8'h80, 8'h80, 1'b1, 1'b0);
      $monitor("w1 a=%b b=%b bin=%b -> diff=%b bout=%b done=%b", s.a, s.b, s.bin, s.diff, s.bout, s.done);
      foreach (combos[k]) begin
         @(negedge clk);
         s.start = 1'b1; s.a = combos[k][2]; s.b = combos[k][1]; s.bin = combos[k][0];
         @(negedge clk);
         s.start = 1'b0;
         check("w1_busy", 32'(s.busy), 1);
         @(negedge clk);
         check("w1_done", 32'(s.done), 1);
         check($sformatf("w1_diff %03b", combos[k]), 32'(s.diff), 32'((int'(combos[k][2]) - int'(combos[k][1]) - int'(combos[k][0])) & 1));
         check($sformatf("w1_bout %03b", combos[k]), 32'(s.bout), 32'(int'(combos[k][2]) < int'(combos[k][1]) + int'(combos[k][0])));
      end
      op8(8'h33, 8'h11, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_hold_diff", 32'(m.diff), 32'(last_d));
         check("idle_busy", 32'(m.busy), 0);
      end
      for (int i = 0; i < 20; i++) op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
      m.start = 1'b1; m.a = 8'h77; m.b = 8'h22; m.bin = 1'b0;
      @(negedge clk);
      m.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(m.busy), 0);
      check("async_rst_done", 32'(m.done), 0);
      check("async_rst_diff", 32'(m.diff), 0);
      check("async_rst_bout", 32'(m.bout), 0);
      @(negedge clk); rst = 1'b0;
      last_d = '0; last_b = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_idle", 32'({m.busy, m.done}), 0);
      op8(8'h10, 8'h01, 1'b0, 1'b0);
      @(negedge clk);
      m.start = 1'b1; m.a = 8'hFF; m.b = 8'h0F; m.bin = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (m.done !== 1'b1 && n < 40);
         check("b2b_done", 32'(m.done), 1);
         check("b2b_spacing", n, k == 0 ? 9 : 10);
         check("b2b_diff", 32'(m.diff), 32'h F0);
         check("b2b_bout", 32'(m.bout), 0);
      end
      m.start = 1'b0;
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial full subtractor: computes diff = a - b - bin over WIDTH bits, LSB first, one bit per clock.
- Built around a single registered full-subtractor cell, the inverse operation of the lab full adder.
- Start/busy/done handshake so a testbench or a small controller can drive it.
- Result and borrow-out are registered and held until the next accepted start.

Parameters:
WIDTH, 8, operand/result width in bits (>= 1)

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous, active-high reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  minuend; sampled on the accepting edge
b      input   WIDTH  subtrahend; sampled on the accepting edge
bin    input   1      borrow-in; sampled on the accepting edge
busy   output  1      1 while in RUN
done   output  1      1 for exactly one cycle (DONE state)
diff   output  WIDTH  registered difference
bout   output  1      registered final borrow-out

Behaviour:
- Reset (async, immediate on rst=1, independent of clk):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow register and bit counter cleared.
- States: IDLE, RUN, DONE. busy and done are decoded from the state register.
- Accepting edge (edge 0): IDLE with start=1.
  - Load opA<=a, opB<=b, brw<=bin, cnt<=0; go to RUN.
- IDLE with start=0: stay; diff/bout hold.
- RUN, each edge (edges 1..WIDTH), with x=opA[0], y=opB[0]:
  - d = x^y^brw.
  - brw <= (~x & y) | (~(x^y) & brw).
  - Result shift register shifts right with d entering at MSB; opA and opB shift right.
  - cnt <= cnt+1.
- On the edge where cnt==WIDTH-1:
  - diff <= the completed result, bout <= that bit's borrow.
  - Go to DONE.
  - diff/bout do NOT change during RUN; they show the previous result.
- DONE: done=1, busy=0 for one cycle; next edge goes to IDLE unconditionally.
- Latency:
  - done is high in the cycle after edge WIDTH, i.e. WIDTH+1 rising edges after start is sampled.
  - Max throughput: one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored; no queuing.
- Changes on a/b/bin after the accepting edge have no effect.
- Arithmetic:
  - Modulo 2^WIDTH two's-complement difference.
  - bout=1 iff a < b+bin as unsigned values.
- Counter width: enough to hold WIDTH-1; no wrap-around inside an operation.
- WIDTH=1: a single RUN cycle; identical truth table to a combinational full subtractor.
- Reset asserted mid-RUN:
  - Operation aborted; all outputs zero immediately.
  - After deassertion, the block waits in IDLE for a new start. No partial result is ever exposed.
- rst and start both high on an edge: reset wins.

Test Plan:
1. WIDTH=8, a=8'h5A, b=8'h3C, bin=0, start pulsed 1 cycle -> busy=1 for 8 cycles, done high 9 edges after start, diff=8'h1E, bout=0.
2. WIDTH=8, a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1; then a=8'h80, b=8'h80, bin=1 -> diff=8'hFF, bout=1.
3. WIDTH=1, all 8 combinations of {a,b,bin} stepped in the same order as the full-adder bench (000,010,100,110,001,011,101,111) -> (diff,bout) = 00,11,10,00,11,01,00,11; $monitor each result.
4. WIDTH=8, assert start again mid-RUN with different a/b -> ignored; result is that of the first operands. After done, diff holds across 5 idle cycles.
5. WIDTH=8, assert rst on the 4th RUN cycle, between clock edges -> busy/done/diff/bout go to 0 without waiting for clk. A later start with a=8'h10, b=8'h01 gives diff=8'h0F, bout=0.
6. Back-to-back: start held high continuously with a=8'hFF, b=8'h0F -> a new operation begins every WIDTH+2 cycles; each done shows diff=8'hF0, bout=0.
